apb_gpio_slave: RTL and testbench
=================================

APB_GPIO_SLAVE -- requirements
Module: apb_gpio_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, PADDR width; PADDR[2:0] is the word-indexed register offset.
REQ-003 SHALL have parameter STRB_WIDTH, default 4, one strobe per data byte.
REQ-004 SHALL have parameter WAIT_STATES, default 1, access-phase wait cycles, range 0..15.
REQ-005 SHALL have parameter GPIO_WIDTH, default 32, pin count, at most DATA_WIDTH.
REQ-006 SHALL have port PCLK  input  1  clock; all logic on the rising edge.
REQ-007 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports PSEL, PENABLE, PWRITE  input  1 each  APB select, enable and direction.
REQ-009 SHALL have ports PADDR  input  ADDRESS_WIDTH, PWDATA  input  DATA_WIDTH, PSTRB  input  STRB_WIDTH.
REQ-010 SHALL have ports PRDATA  output  DATA_WIDTH, PREADY  output  1, PSLVERR  output  1.
REQ-011 SHALL have ports GPIO_IN  input  GPIO_WIDTH (asynchronous pins), GPIO_OUT  output  GPIO_WIDTH, GPIO_OE  output  GPIO_WIDTH, IRQ  output  1.

Function
REQ-012 SHALL implement the register map: 0 DATA_OUT RW, 1 DIR RW, 2 DATA_IN RO, 3 IRQ_EN RW, 4 IRQ_STATUS W1C, 5 ID RO = 32'h6710_0001; offsets 6 and 7 are unmapped.
REQ-013 SHALL use a transfer FSM with states IDLE, WAIT and DONE: IDLE->WAIT on PSEL&!PENABLE (setup phase), loading the counter with WAIT_STATES.
REQ-014 SHALL, in WAIT with PSEL&PENABLE, decrement the counter while it is nonzero, and go WAIT->DONE when the counter is 0.
REQ-015 SHALL drive PREADY=1 in WAIT when the counter is 0 and 0 otherwise, so PREADY rises in access cycle WAIT_STATES+1 (the first access cycle when WAIT_STATES=0).
REQ-016 SHALL go DONE->IDLE unconditionally; a setup phase seen in DONE goes directly to WAIT, supporting back-to-back transfers.
REQ-017 SHALL commit a write only in the cycle where PSEL&PENABLE&PREADY&PWRITE&!PSLVERR holds, updating only the bytes whose PSTRB bit is 1.
REQ-018 SHALL drive PRDATA with the addressed register (zero-extended to DATA_WIDTH) when PREADY&!PWRITE, and 0 otherwise.
REQ-019 SHALL assert PSLVERR only together with PREADY, for: an unmapped offset, a write to DATA_IN or ID, or PADDR[3]=1; an erroring transfer changes no register.
REQ-020 SHALL drive GPIO_OUT=DATA_OUT and GPIO_OE=DIR directly from registers, with no combinational path from the APB inputs.
REQ-021 SHALL make DATA_IN read the GPIO_IN value after a 2-flop synchronizer, giving 2-3 PCLK of latency.
REQ-022 SHALL set IRQ_STATUS[i] on a synchronized rising edge of pin i when IRQ_EN[i]=1; a W1C write to IRQ_STATUS clears the bits written as 1.
REQ-023 SHALL let a set win over a W1C clear of the same bit in the same cycle.
REQ-024 SHALL drive IRQ as a register equal to |(IRQ_STATUS & IRQ_EN), one PCLK after the status change.
REQ-025 SHALL, when PSEL drops mid-transfer (WAIT), return the FSM to IDLE next cycle with no register write and PREADY=0.

Reset
REQ-026 SHALL, while PRESETn=0, asynchronously clear the FSM (to IDLE), counter, DATA_OUT, DIR, IRQ_EN, IRQ_STATUS, synchronizer flops, IRQ, PREADY and PSLVERR, and hold PRDATA at 0.
REQ-027 SHALL, when reset is asserted mid-transfer, abandon the transfer without committing it; GPIO_OE=0 puts all pins in input mode.

Configuration
REQ-028 SHALL, with GPIO_IRQ_EN defined, implement IRQ_EN, IRQ_STATUS, edge detection and IRQ as specified.
REQ-029 SHALL, without GPIO_IRQ_EN, treat offsets 3 and 4 as unmapped (PSLVERR) and tie IRQ to 0, with no interrupt flops inferred.

Structure
REQ-030 SHALL place the register offsets, the ID value and the FSM state encoding in the shared package apb_gpio_pkg.
REQ-031 SHALL implement the synchronizer and rising-edge detect in the sub-module gpio_sync_edge, parameterized by width.

Verification
REQ-032 SHALL check: WAIT_STATES=1, write 0xA5A5A5A5 to offset 0 with PSTRB=4'b0011 -> PREADY in access cycle 2, GPIO_OUT=0x0000A5A5, PSLVERR=0.
REQ-033 SHALL check: WAIT_STATES=0, read offset 5 -> PREADY in access cycle 1, PRDATA=0x67100001.
REQ-034 SHALL check: write offset 2, then read offset 6 -> PSLVERR=1 with PREADY on both, and DATA_IN and all other registers unchanged.
REQ-035 SHALL check (GPIO_IRQ_EN): IRQ_EN=0x1, GPIO_IN[0] goes 0->1 -> IRQ_STATUS=0x1 and IRQ=1 within 4 PCLK; W1C write of 0x1 -> IRQ=0.
REQ-036 SHALL check: a W1C clear of bit 0 in the same cycle as a new edge on pin 0 -> IRQ_STATUS[0] stays 1.
REQ-037 SHALL check: PRESETn pulled low during WAIT of a write of 0xFFFFFFFF to offset 1 -> GPIO_OE=0, PREADY=0, and DIR reads 0 after release.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_pkg
// Purpose  : Shared definitions for the APB GPIO slave: register offsets,
//            ID value, transfer FSM state encoding and address-decode helpers.
// Ports    : none (package)
// Config   : GPIO_IRQ_EN is consumed by the importing modules, not here.
// Revision : 1.0 - initial release
// ============================================================================
package apb_gpio_pkg;

    // Word-indexed register offsets (PADDR[2:0])
    localparam logic [2:0] OFF_DATA_OUT   = 3'd0;
    localparam logic [2:0] OFF_DIR        = 3'd1;
    localparam logic [2:0] OFF_DATA_IN    = 3'd2;
    localparam logic [2:0] OFF_IRQ_EN     = 3'd3;
    localparam logic [2:0] OFF_IRQ_STATUS = 3'd4;
    localparam logic [2:0] OFF_ID         = 3'd5;

    localparam logic [31:0] GPIO_ID_VALUE = 32'h6710_0001;

    // Wait-state counter width: WAIT_STATES spans 0..15
    localparam int unsigned WAIT_CNT_W = 4;

    // Transfer FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Offset decodes to a register in this build
    function automatic logic off_is_mapped(input logic [2:0] off, input logic has_irq);
        logic r;
        r = (off == OFF_DATA_OUT) || (off == OFF_DIR) || (off == OFF_DATA_IN) ||
            (off == OFF_ID) ||
            (has_irq && ((off == OFF_IRQ_EN) || (off == OFF_IRQ_STATUS)));
        return r;
    endfunction

    // Offset refuses writes
    function automatic logic off_is_read_only(input logic [2:0] off);
        return (off == OFF_DATA_IN) || (off == OFF_ID);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : gpio_sync_edge
// Purpose  : Two-flop synchronizer for asynchronous GPIO pins with an optional
//            per-pin rising-edge detector on the synchronized value.
// Ports    : clk_i   - clock
//            rst_ni  - asynchronous active-low reset
//            async_i - raw pin values
//            sync_o  - synchronized pin values (2-3 clk latency)
//            rise_o  - one-cycle pulse per synchronized 0->1 transition
// Params   : WIDTH   - pin count
//            EDGE_EN - 1 builds the edge detector, 0 ties rise_o to zero
// Revision : 1.0 - initial release
// ============================================================================
module gpio_sync_edge #(
    parameter int WIDTH   = 32,
    parameter bit EDGE_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

    generate
        if (EDGE_EN) begin : g_edge
            logic [WIDTH-1:0] prev_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    prev_q <= '0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign rise_o = sync_q & ~prev_q;
        end else begin : g_no_edge
            assign rise_o = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_gpio_slave
// Purpose  : APB slave exposing a GPIO block: output data, direction, pin
//            input, and (optionally) edge-triggered interrupts.
// Ports    : PCLK, PRESETn (async, active-low)
//            PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB  - APB request
//            PRDATA, PREADY, PSLVERR                      - APB response
//            GPIO_IN (async pins), GPIO_OUT, GPIO_OE, IRQ
// Config   : define GPIO_IRQ_EN to build IRQ_EN / IRQ_STATUS / IRQ; without
//            it offsets 3 and 4 answer with PSLVERR and IRQ is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module apb_gpio_slave
    import apb_gpio_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 4,
    parameter int STRB_WIDTH    = 4,
    parameter int WAIT_STATES   = 1,
    parameter int GPIO_WIDTH    = 32
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [ADDRESS_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0]    PWDATA,
    input  logic [STRB_WIDTH-1:0]    PSTRB,
    output logic [DATA_WIDTH-1:0]    PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [GPIO_WIDTH-1:0]    GPIO_IN,
    output logic [GPIO_WIDTH-1:0]    GPIO_OUT,
    output logic [GPIO_WIDTH-1:0]    GPIO_OE,
    output logic                     IRQ
);

`ifdef GPIO_IRQ_EN
    localparam logic c_has_irq = 1'b1;
`else
    localparam logic c_has_irq = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] c_wait_init = WAIT_CNT_W'(WAIT_STATES);

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    logic       w_setup;
    logic       w_access;
    logic [2:0] w_off;

    assign w_setup  = PSEL & ~PENABLE;
    assign w_access = PSEL & PENABLE;
    assign w_off    = PADDR[2:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            // DONE behaves like IDLE so a setup phase right after a
            // completed transfer starts the next one without a bubble.
            ST_IDLE, ST_DONE: begin
                if (w_setup) begin
                    state_d = ST_WAIT;
                    cnt_d   = c_wait_init;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (w_access) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // PSEL gating keeps PREADY low in the cycle a master abandons a transfer.
    assign PREADY = (state_q == ST_WAIT) && (cnt_q == '0) && PSEL;

    // ------------------------------------------------------------------
    // Address decode and response
    // ------------------------------------------------------------------
    logic w_dec_err;
    logic w_wr_en;

    assign w_dec_err = PADDR[3] | ~off_is_mapped(w_off, c_has_irq) |
                       (PWRITE & off_is_read_only(w_off));
    assign PSLVERR   = PREADY & w_dec_err;
    assign w_wr_en   = w_access & PREADY & PWRITE & ~PSLVERR;

    // Byte-strobe expansion, then narrowed to the pin width
    logic [DATA_WIDTH-1:0] w_bmask;
    logic [GPIO_WIDTH-1:0] w_wmask;
    logic [GPIO_WIDTH-1:0] w_wbits;

    generate
        for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_bmask
            assign w_bmask[b*8 +: 8] = {8{PSTRB[b]}};
        end
    endgenerate

    assign w_wmask = w_bmask[GPIO_WIDTH-1:0];
    assign w_wbits = PWDATA[GPIO_WIDTH-1:0] & w_wmask;

    // ------------------------------------------------------------------
    // Pin synchronizer / edge detect
    // ------------------------------------------------------------------
    logic [GPIO_WIDTH-1:0] w_gpio_sync;
    logic [GPIO_WIDTH-1:0] w_gpio_rise;

    gpio_sync_edge #(
        .WIDTH   (GPIO_WIDTH),
        .EDGE_EN (c_has_irq)
    ) u_sync (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .async_i (GPIO_IN),
        .sync_o  (w_gpio_sync),
        .rise_o  (w_gpio_rise)
    );

    // ------------------------------------------------------------------
    // DATA_OUT / DIR
    // ------------------------------------------------------------------
    logic [GPIO_WIDTH-1:0] data_out_q, data_out_d;
    logic [GPIO_WIDTH-1:0] dir_q, dir_d;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        if (w_wr_en) begin
            case (w_off)
                OFF_DATA_OUT: data_out_d = (data_out_q & ~w_wmask) | w_wbits;
                OFF_DIR:      dir_d      = (dir_q & ~w_wmask) | w_wbits;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_out_q <= '0;
            dir_q      <= '0;
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
        end
    end

    assign GPIO_OUT = data_out_q;
    assign GPIO_OE  = dir_q;

    // ------------------------------------------------------------------
    // Interrupts
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rd_irq_en;
    logic [DATA_WIDTH-1:0] w_rd_irq_status;

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
    logic [GPIO_WIDTH-1:0] irq_status_q, irq_status_d;
    logic [GPIO_WIDTH-1:0] w_irq_clr;
    logic                  irq_q;

    always_comb begin
        irq_en_d  = irq_en_q;
        w_irq_clr = '0;
        if (w_wr_en && (w_off == OFF_IRQ_EN)) begin
            irq_en_d = (irq_en_q & ~w_wmask) | w_wbits;
        end
        if (w_wr_en && (w_off == OFF_IRQ_STATUS)) begin
            w_irq_clr = w_wbits;
        end
        // Set is applied after the clear so a coincident edge is never lost.
        irq_status_d = (irq_status_q & ~w_irq_clr) | (w_gpio_rise & irq_en_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            irq_en_q     <= '0;
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_en_q     <= irq_en_d;
            irq_status_q <= irq_status_d;
            irq_q        <= |(irq_status_q & irq_en_q);
        end
    end

    assign IRQ             = irq_q;
    assign w_rd_irq_en     = DATA_WIDTH'(irq_en_q);
    assign w_rd_irq_status = DATA_WIDTH'(irq_status_q);
`else
    logic w_unused_rise;

    assign w_unused_rise   = |w_gpio_rise;
    assign IRQ             = 1'b0;
    assign w_rd_irq_en     = '0;
    assign w_rd_irq_status = '0;
`endif

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            OFF_DATA_OUT:   w_rdata = DATA_WIDTH'(data_out_q);
            OFF_DIR:        w_rdata = DATA_WIDTH'(dir_q);
            OFF_DATA_IN:    w_rdata = DATA_WIDTH'(w_gpio_sync);
            OFF_IRQ_EN:     w_rdata = w_rd_irq_en;
            OFF_IRQ_STATUS: w_rdata = w_rd_irq_status;
            OFF_ID:         w_rdata = DATA_WIDTH'(GPIO_ID_VALUE);
            default:        w_rdata = '0;
        endcase
    end

    assign PRDATA = (PREADY && !PWRITE) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_gpio_slave
// Purpose  : Self-checking bench for apb_gpio_slave. Two instances share the
//            APB bus (separate PSEL): u_dut0 with WAIT_STATES=1, u_dut1 with
//            WAIT_STATES=0. Interrupt scenarios depend on GPIO_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_gpio_slave;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL0, PSEL1, PENABLE, PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] GPIO_IN;

    logic [31:0] PRDATA0, PRDATA1, GPIO_OUT0, GPIO_OUT1, GPIO_OE0, GPIO_OE1;
    logic        PREADY0, PREADY1, PSLVERR0, PSLVERR1, IRQ0, IRQ1;

    always #5 PCLK = ~PCLK;

    apb_gpio_slave #(.WAIT_STATES(1)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL0), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA0), .PREADY(PREADY0), .PSLVERR(PSLVERR0),
        .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT0), .GPIO_OE(GPIO_OE0), .IRQ(IRQ0)
    );

    apb_gpio_slave #(.WAIT_STATES(0)) u_dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL1), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA1), .PREADY(PREADY1), .PSLVERR(PSLVERR1),
        .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT1), .GPIO_OE(GPIO_OE1), .IRQ(IRQ1)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  cyc;   // access cycle in which PREADY was seen
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] exp_dout0;

    function automatic txn_t mk(input logic [31:0] d, input logic e, input logic [7:0] c);
        txn_t t;
        t.rdata = d;
        t.err   = e;
        t.cyc   = c;
        return t;
    endfunction

    // One APB transfer to instance sel, starting at the current time (which
    // is always just after a rising edge). Ends just after the completing
    // edge with the bus released, so consecutive calls are back-to-back.
    task automatic xfer(input int sel, input logic wr, input logic [3:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb);
        txn_t o;
        bit   done;
        o    = '0;
        done = 1'b0;
        PSEL0 = (sel == 0); PSEL1 = (sel == 1);
        PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 1; i <= 20 && !done; i++) begin
            @(negedge PCLK);
            if ((sel == 0) ? PREADY0 : PREADY1) begin
                done    = 1'b1;
                o.cyc   = 8'(i);
                o.rdata = (sel == 0) ? PRDATA0 : PRDATA1;
                o.err   = (sel == 0) ? PSLVERR0 : PSLVERR1;
            end
            @(posedge PCLK); #1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL xfer_timeout: dut%0d addr %h PREADY=0 after 20 cycles, required 1", sel, addr);
        end
        PSEL0 = 1'b0; PSEL1 = 1'b0; PENABLE = 1'b0;
        obs_q.push_back(o);
    endtask

    task automatic test_reset;
        txn_t e, o;
        PRESETn = 1'b0; GPIO_IN = '0;
        PSEL0 = 1'b1; PSEL1 = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
        PADDR = 4'd5; PWDATA = '0; PSTRB = '0;
        repeat (3) @(posedge PCLK);
        #1;
        n_vec++;
        if ({PREADY0, PSLVERR0, PREADY1, IRQ0, IRQ1} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_handshake: got rdy0/err0/rdy1/irq0/irq1=%b required 00000",
                     {PREADY0, PSLVERR0, PREADY1, IRQ0, IRQ1});
        end
        n_vec++;
        if ({PRDATA0, PRDATA1} !== 64'h0) begin
            n_err++; $display("FAIL reset_prdata: got %h/%h required 0", PRDATA0, PRDATA1);
        end
        n_vec++;
        if ({GPIO_OUT0, GPIO_OE0, GPIO_OE1} !== 96'h0) begin
            n_err++; $display("FAIL reset_pins: got out %h oe %h/%h required 0", GPIO_OUT0, GPIO_OE0, GPIO_OE1);
        end
        PSEL0 = 1'b0; PSEL1 = 1'b0; PENABLE = 1'b0;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd0, '0, 4'h0);
        exp_q.push_back(mk(32'h0, 1'b0, 8'd1)); xfer(1, 1'b0, 4'd1, '0, 4'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_regs: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask

    task automatic test_write_strobe;
        txn_t e, o;
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b1, 4'd0, 32'hA5A5_A5A5, 4'b0011);
        n_vec++;
        if (GPIO_OUT0 !== 32'h0000_A5A5) begin
            n_err++; $display("FAIL strobe_low_pins: got %h required 0000a5a5", GPIO_OUT0);
        end
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b1, 4'd0, 32'h1234_5678, 4'b1100);
        exp_q.push_back(mk(32'h1234_A5A5, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd0, '0, 4'h0);
        exp_dout0 = 32'h1234_A5A5;
        n_vec++;
        if (GPIO_OUT0 !== exp_dout0) begin
            n_err++; $display("FAIL strobe_high_pins: got %h required %h", GPIO_OUT0, exp_dout0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL write_strobe: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask

    task automatic test_id_wait_states;
        txn_t e, o;
        exp_q.push_back(mk(32'h6710_0001, 1'b0, 8'd1)); xfer(1, 1'b0, 4'd5, '0, 4'h0);
        exp_q.push_back(mk(32'h6710_0001, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd5, '0, 4'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL id_read: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask

    task automatic test_back_to_back;
        txn_t e, o;
        exp_q.push_back(mk(32'h0, 1'b0, 8'd1));         xfer(1, 1'b1, 4'd0, 32'h1111_1111, 4'hF);
        exp_q.push_back(mk(32'h1111_1111, 1'b0, 8'd1)); xfer(1, 1'b0, 4'd0, '0, 4'h0);
        exp_q.push_back(mk(32'h0, 1'b0, 8'd1));         xfer(1, 1'b1, 4'd1, 32'h0000_FFFF, 4'b0001);
        exp_q.push_back(mk(32'h0000_00FF, 1'b0, 8'd1)); xfer(1, 1'b0, 4'd1, '0, 4'h0);
        n_vec++;
        if ({GPIO_OUT1, GPIO_OE1} !== {32'h1111_1111, 32'h0000_00FF}) begin
            n_err++; $display("FAIL b2b_pins: got out %h oe %h required 11111111 000000ff", GPIO_OUT1, GPIO_OE1);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL back_to_back: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask

    task automatic test_errors;
        txn_t e, o;
        GPIO_IN = 32'h0F0F_0F0F;
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2));         xfer(0, 1'b1, 4'd1, 32'h0000_FF00, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1, 8'd2));         xfer(0, 1'b1, 4'd2, 32'hFFFF_FFFF, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1, 8'd2));         xfer(0, 1'b0, 4'd6, '0, 4'h0);
        exp_q.push_back(mk(32'h0F0F_0F0F, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd2, '0, 4'h0);
        exp_q.push_back(mk(32'h0, 1'b1, 8'd2));         xfer(0, 1'b1, 4'd5, 32'h0, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1, 8'd2));         xfer(0, 1'b1, 4'd8, 32'h0, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1, 8'd2));         xfer(0, 1'b0, 4'd7, '0, 4'h0);
        exp_q.push_back(mk(exp_dout0, 1'b0, 8'd2));     xfer(0, 1'b0, 4'd0, '0, 4'h0);
        exp_q.push_back(mk(32'h0000_FF00, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd1, '0, 4'h0);
        exp_q.push_back(mk(32'h6710_0001, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd5, '0, 4'h0);
        n_vec++;
        if ({GPIO_OUT0, GPIO_OE0} !== {exp_dout0, 32'h0000_FF00}) begin
            n_err++; $display("FAIL err_pins: got out %h oe %h required %h 0000ff00", GPIO_OUT0, GPIO_OE0, exp_dout0);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL errors: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask

    task automatic test_psel_drop;
        txn_t e, o;
        PSEL0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd0;
        PWDATA = 32'hDEAD_BEEF; PSTRB = 4'hF;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(negedge PCLK);
        n_vec++;
        if (PREADY0 !== 1'b0) begin
            n_err++; $display("FAIL drop_wait1_ready: got %b required 0", PREADY0);
        end
        @(posedge PCLK); #1; PSEL0 = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        n_vec++;
        if (PREADY0 !== 1'b0) begin
            n_err++; $display("FAIL drop_ready: got %b required 0", PREADY0);
        end
        repeat (2) @(posedge PCLK);
        #1;
        n_vec++;
        if (GPIO_OUT0 !== exp_dout0) begin
            n_err++; $display("FAIL drop_no_write: got %h required %h", GPIO_OUT0, exp_dout0);
        end
        exp_q.push_back(mk(exp_dout0, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd0, '0, 4'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL psel_drop: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask

`ifdef GPIO_IRQ_EN
    task automatic test_irq;
        txn_t e, o;
        bit   seen;
        GPIO_IN = '0;
        repeat (4) @(posedge PCLK);
        #1;
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b1, 4'd3, 32'h1, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd4, '0, 4'h0);
        GPIO_IN = 32'h1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(posedge PCLK); #1;
            seen = IRQ0;
        end
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL irq_rise: got IRQ=%b within 4 PCLK required 1", IRQ0);
        end
        exp_q.push_back(mk(32'h1, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd4, '0, 4'h0);
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b1, 4'd4, 32'h1, 4'hF);
        @(posedge PCLK); #1;
        n_vec++;
        if (IRQ0 !== 1'b0) begin
            n_err++; $display("FAIL irq_w1c: got IRQ=%b required 0", IRQ0);
        end
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd4, '0, 4'h0);
        // Rising edge timed so its set lands on the W1C commit edge
        GPIO_IN = '0;
        repeat (4) @(posedge PCLK);
        #1;
        GPIO_IN = 32'h1;
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b1, 4'd4, 32'h1, 4'hF);
        exp_q.push_back(mk(32'h1, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd4, '0, 4'h0);
        n_vec++;
        if (IRQ0 !== 1'b1) begin
            n_err++; $display("FAIL irq_set_wins: got IRQ=%b required 1", IRQ0);
        end
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b1, 4'd4, 32'h1, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd4, '0, 4'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL irq: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask
`else
    task automatic test_no_irq;
        txn_t e, o;
        exp_q.push_back(mk(32'h0, 1'b1, 8'd2)); xfer(0, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1, 8'd2)); xfer(0, 1'b0, 4'd3, '0, 4'h0);
        exp_q.push_back(mk(32'h0, 1'b1, 8'd2)); xfer(0, 1'b1, 4'd4, 32'h1, 4'hF);
        exp_q.push_back(mk(32'h0, 1'b1, 8'd1)); xfer(1, 1'b0, 4'd4, '0, 4'h0);
        GPIO_IN = '0;
        repeat (4) @(posedge PCLK);
        #1;
        GPIO_IN = 32'hFFFF_FFFF;
        repeat (6) @(posedge PCLK);
        #1;
        n_vec++;
        if ({IRQ0, IRQ1} !== 2'b00) begin
            n_err++; $display("FAIL no_irq_tied: got %b required 00", {IRQ0, IRQ1});
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL no_irq: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask
`endif

    task automatic test_reset_mid;
        txn_t e, o;
        PSEL0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd1;
        PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        n_vec++;
        if ({GPIO_OE0, PREADY0} !== 33'h0) begin
            n_err++; $display("FAIL rstmid_async: got oe %h ready %b required 0 0", GPIO_OE0, PREADY0);
        end
        repeat (2) @(posedge PCLK);
        #1;
        PSEL0 = 1'b0; PENABLE = 1'b0;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        n_vec++;
        if ({GPIO_OE0, GPIO_OUT0} !== 64'h0) begin
            n_err++; $display("FAIL rstmid_pins: got oe %h out %h required 0 0", GPIO_OE0, GPIO_OUT0);
        end
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd1, '0, 4'h0);
        exp_q.push_back(mk(32'h0, 1'b0, 8'd2)); xfer(0, 1'b0, 4'd0, '0, 4'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_mid: got %h/%b/%0d required %h/%b/%0d", o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
            end
        end
    endtask

    initial begin
        exp_dout0 = '0;
        test_reset();
        test_write_strobe();
        test_id_wait_states();
        test_back_to_back();
        test_errors();
        test_psel_drop();
`ifdef GPIO_IRQ_EN
        test_irq();
`else
        test_no_irq();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
